// File: rtl/intf_arb_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | intf_arb_pkg - shared types for the SPI/QSPI arbiter      rev 1.0 |
// +-------------------------------------------------------------------+
`ifndef INTERFACE_DATA_WIDTH
`define INTERFACE_DATA_WIDTH 16
`endif
`ifndef INTERFACE_ADDR_WIDTH
`define INTERFACE_ADDR_WIDTH 8
`endif

package intf_arb_pkg;
  localparam int IFC_DW = `INTERFACE_DATA_WIDTH;
  localparam int IFC_AW = `INTERFACE_ADDR_WIDTH;
  localparam int DROP_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  typedef enum logic {
    OWN_SPI  = 1'b0,
    OWN_QSPI = 1'b1
  } owner_t;

  typedef struct packed {
    logic [IFC_AW-1:0] addr;
    logic [IFC_DW-1:0] wdata;
    logic              is_write;
  } req_t;
endpackage
`default_nettype wire

// File: rtl/intf_req_buf.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | intf_req_buf - one-entry request buffer, freed on grant   rev 1.0 |
// +-------------------------------------------------------------------+
module intf_req_buf
  import intf_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IFC_AW-1:0] addr_i,
  input  logic [IFC_DW-1:0] wdata_i,
  input  logic              wen_i,
  input  logic              ren_i,
  input  logic              grant_i,
  output logic              full_o,
  output logic [IFC_AW-1:0] addr_o,
  output logic [IFC_DW-1:0] wdata_o,
  output logic              is_write_o,
  output logic [1:0]        drop_o
);
  req_t req_q, req_d;
  logic full_q, full_d;
  logic pulse, capture;

  always_comb begin
    pulse   = wen_i | ren_i;
    capture = pulse & (~full_q | grant_i);
    req_d   = req_q;
    full_d  = full_q & ~grant_i;
    drop_o  = 2'd0;
    if (capture) begin
      req_d  = '{addr: addr_i, wdata: wdata_i, is_write: wen_i};
      full_d = 1'b1;
      // a simultaneous read rides along with the captured write and is lost
      drop_o = {1'b0, wen_i & ren_i};
    end else if (pulse) begin
      drop_o = {1'b0, wen_i} + {1'b0, ren_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      full_q <= 1'b0;
    end else begin
      req_q  <= req_d;
      full_q <= full_d;
    end
  end

  assign full_o     = full_q;
  assign addr_o     = req_q.addr;
  assign wdata_o    = req_q.wdata;
  assign is_write_o = req_q.is_write;
endmodule
`default_nettype wire

// File: rtl/intf_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | intf_arbiter - SPI/QSPI to array_top single-txn arbiter   rev 1.0 |
// +-------------------------------------------------------------------+
module intf_arbiter
  import intf_arb_pkg::*;
#(
  parameter int            DW           = IFC_DW,
  parameter int            AW           = IFC_AW,
  parameter int            RD_TIMEOUT   = 255,
  parameter logic [DW-1:0] TIMEOUT_DATA = '1,
  parameter int            STARVE_LIM   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] spi_addr_i,
  input  logic          spi_wen_i,
  input  logic          spi_ren_i,
  input  logic [DW-1:0] spi_wdata_i,
  output logic [DW-1:0] spi_rdata_o,
  output logic          spi_rvalid_o,
  input  logic [AW-1:0] qspi_addr_i,
  input  logic          qspi_wen_i,
  input  logic          qspi_ren_i,
  input  logic [DW-1:0] qspi_wdata_i,
  output logic [DW-1:0] qspi_rdata_o,
  output logic          qspi_rvalid_o,
  output logic [AW-1:0] ifc_addr_o,
  output logic          ifc_wen_o,
  output logic [DW-1:0] ifc_wdata_o,
  output logic          ifc_ren_o,
  input  logic [DW-1:0] ifc_rdata_i,
  input  logic          ifc_rvalid_i,
  output logic          rd_timeout_o,
  output logic [1:0]    err_sticky_o,
  output logic [7:0]    drop_cnt_o
);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(RD_TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  logic          spi_full, qspi_full, spi_isw, qspi_isw;
  logic [AW-1:0] spi_baddr, qspi_baddr;
  logic [DW-1:0] spi_bwdata, qspi_bwdata;
  logic [1:0]    spi_drop, qspi_drop;
  logic          grant_spi, grant_qspi, qspi_turn;
  req_t          sel_req;
  logic [DW-1:0] resp_data;
  logic [DROP_W+2:0] drop_tot;
  logic [DROP_W-1:0] drop_cnt_d;

  state_t        state_q;
  owner_t        owner_q;
  logic [SW-1:0] starve_q;
  logic [TW-1:0] timer_q;
  logic [AW-1:0] ifc_addr_q;
  logic [DW-1:0] ifc_wdata_q, spi_rdata_q, qspi_rdata_q;
  logic          ifc_wen_q, ifc_ren_q, spi_rvalid_q, qspi_rvalid_q, rd_timeout_q;
  logic [1:0]    err_sticky_q;
  logic [DROP_W-1:0] drop_cnt_q;

  intf_req_buf u_spi_buf (
    .clk(clk), .rst_n(rst_n), .addr_i(spi_addr_i), .wdata_i(spi_wdata_i),
    .wen_i(spi_wen_i), .ren_i(spi_ren_i), .grant_i(grant_spi), .full_o(spi_full),
    .addr_o(spi_baddr), .wdata_o(spi_bwdata), .is_write_o(spi_isw), .drop_o(spi_drop)
  );

  intf_req_buf u_qspi_buf (
    .clk(clk), .rst_n(rst_n), .addr_i(qspi_addr_i), .wdata_i(qspi_wdata_i),
    .wen_i(qspi_wen_i), .ren_i(qspi_ren_i), .grant_i(grant_qspi), .full_o(qspi_full),
    .addr_o(qspi_baddr), .wdata_o(qspi_bwdata), .is_write_o(qspi_isw), .drop_o(qspi_drop)
  );

  always_comb begin
    qspi_turn  = qspi_full && (starve_q == STARVE_MAX);
    grant_spi  = (state_q == IDLE) && spi_full && !qspi_turn;
    grant_qspi = (state_q == IDLE) && qspi_full && !grant_spi;
    sel_req    = grant_qspi ? '{addr: qspi_baddr, wdata: qspi_bwdata, is_write: qspi_isw}
                            : '{addr: spi_baddr,  wdata: spi_bwdata,  is_write: spi_isw};
    resp_data  = ifc_rvalid_i ? ifc_rdata_i : TIMEOUT_DATA;
    drop_tot   = {3'b000, drop_cnt_q} + {{(DROP_W - 1){1'b0}}, spi_drop} + {{(DROP_W - 1){1'b0}}, qspi_drop};
    drop_cnt_d = (drop_tot > {3'b000, {DROP_W{1'b1}}}) ? {DROP_W{1'b1}} : drop_tot[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= OWN_SPI;
      starve_q      <= '0;
      timer_q       <= '0;
      ifc_addr_q    <= '0;
      ifc_wdata_q   <= '0;
      ifc_wen_q     <= 1'b0;
      ifc_ren_q     <= 1'b0;
      spi_rdata_q   <= '0;
      qspi_rdata_q  <= '0;
      spi_rvalid_q  <= 1'b0;
      qspi_rvalid_q <= 1'b0;
      rd_timeout_q  <= 1'b0;
      err_sticky_q  <= 2'b00;
      drop_cnt_q    <= '0;
    end else begin
      ifc_wen_q     <= 1'b0;
      ifc_ren_q     <= 1'b0;
      spi_rvalid_q  <= 1'b0;
      qspi_rvalid_q <= 1'b0;
      rd_timeout_q  <= 1'b0;
      drop_cnt_q    <= drop_cnt_d;
      if ((spi_drop != 2'd0) || (qspi_drop != 2'd0)) err_sticky_q[0] <= 1'b1;
      if (ifc_rvalid_i && (state_q != WAIT_RD)) err_sticky_q[1] <= 1'b1;
      case (state_q)
        IDLE: begin
          if (grant_spi || grant_qspi) begin
            owner_q     <= grant_qspi ? OWN_QSPI : OWN_SPI;
            ifc_addr_q  <= sel_req.addr;
            ifc_wdata_q <= sel_req.wdata;
            ifc_wen_q   <= sel_req.is_write;
            ifc_ren_q   <= !sel_req.is_write;
            state_q     <= ISSUE;
            // only SPI wins taken over a waiting QSPI count toward starvation
            if (grant_qspi) starve_q <= '0;
            else if (qspi_full) starve_q <= starve_q + SW'(1);
          end
        end
        ISSUE: begin
          timer_q <= '0;
          state_q <= ifc_ren_q ? WAIT_RD : IDLE;
        end
        WAIT_RD: begin
          if (ifc_rvalid_i || (timer_q == TMO_LAST)) begin
            if (owner_q == OWN_QSPI) begin
              qspi_rdata_q  <= resp_data;
              qspi_rvalid_q <= 1'b1;
            end else begin
              spi_rdata_q  <= resp_data;
              spi_rvalid_q <= 1'b1;
            end
            rd_timeout_q <= !ifc_rvalid_i;
            state_q      <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ifc_addr_o    = ifc_addr_q;
  assign ifc_wdata_o   = ifc_wdata_q;
  assign ifc_wen_o     = ifc_wen_q;
  assign ifc_ren_o     = ifc_ren_q;
  assign spi_rdata_o   = spi_rdata_q;
  assign spi_rvalid_o  = spi_rvalid_q;
  assign qspi_rdata_o  = qspi_rdata_q;
  assign qspi_rvalid_o = qspi_rvalid_q;
  assign rd_timeout_o  = rd_timeout_q;
  assign err_sticky_o  = err_sticky_q;
  assign drop_cnt_o    = drop_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_intf_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_intf_arbiter - directed scoreboard bench for intf_arbiter rev 1.0 |
// +-------------------------------------------------------------------+
module tb_intf_arbiter;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] spi_addr = '0, qspi_addr = '0;
  logic          spi_wen = 1'b0, spi_ren = 1'b0, qspi_wen = 1'b0, qspi_ren = 1'b0;
  logic [DW-1:0] spi_wdata = '0, qspi_wdata = '0, ifc_rdata = '0;
  logic          ifc_rvalid = 1'b0;
  logic [DW-1:0] spi_rdata, qspi_rdata, ifc_wdata;
  logic          spi_rvalid, qspi_rvalid, ifc_wen, ifc_ren, rd_timeout;
  logic [AW-1:0] ifc_addr;
  logic [1:0]    err_sticky;
  logic [7:0]    drop_cnt;

  typedef struct packed {logic wen; logic ren; logic [AW-1:0] addr; logic [DW-1:0] wdata;} ifc_t;
  typedef struct packed {logic spi; logic qspi; logic [DW-1:0] data;} rd_t;
  ifc_t exq[$];
  rd_t  rdq[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   to_cnt = 0;

  intf_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .spi_addr_i(spi_addr), .spi_wen_i(spi_wen), .spi_ren_i(spi_ren), .spi_wdata_i(spi_wdata),
    .spi_rdata_o(spi_rdata), .spi_rvalid_o(spi_rvalid),
    .qspi_addr_i(qspi_addr), .qspi_wen_i(qspi_wen), .qspi_ren_i(qspi_ren), .qspi_wdata_i(qspi_wdata),
    .qspi_rdata_o(qspi_rdata), .qspi_rvalid_o(qspi_rvalid),
    .ifc_addr_o(ifc_addr), .ifc_wen_o(ifc_wen), .ifc_wdata_o(ifc_wdata), .ifc_ren_o(ifc_ren),
    .ifc_rdata_i(ifc_rdata), .ifc_rvalid_i(ifc_rvalid),
    .rd_timeout_o(rd_timeout), .err_sticky_o(err_sticky), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    ifc_t got;
    rd_t  rgot;
    if (ifc_wen || ifc_ren) begin
      got = '{wen: ifc_wen, ren: ifc_ren, addr: ifc_addr, wdata: (ifc_wen ? ifc_wdata : '0)};
      if (exq.size() == 0) check("ifc_unexpected", 64'(got), 64'(0));
      else check("ifc_txn", 64'(got), 64'(exq.pop_front()));
    end
    if (spi_rvalid || qspi_rvalid) begin
      rgot = '{spi: spi_rvalid, qspi: qspi_rvalid, data: (spi_rvalid ? spi_rdata : qspi_rdata)};
      if (rdq.size() == 0) check("rvalid_unexpected", 64'(rgot), 64'(0));
      else check("rd_return", 64'(rgot), 64'(rdq.pop_front()));
    end
    if (rd_timeout) to_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic drive(input bit q, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit expect_txn);
    if (q) begin
      qspi_wen = w; qspi_ren = !w; qspi_addr = a; qspi_wdata = d;
    end else begin
      spi_wen = w; spi_ren = !w; spi_addr = a; spi_wdata = d;
    end
    if (expect_txn) exq.push_back('{wen: w, ren: !w, addr: a, wdata: (w ? d : '0)});
  endtask

  task automatic clr();
    spi_wen = 1'b0; spi_ren = 1'b0; qspi_wen = 1'b0; qspi_ren = 1'b0;
  endtask

  task automatic wait_strobe(input int lim);
    int k = 0;
    while (!(ifc_wen || ifc_ren) && k < lim) begin
      tick();
      k++;
    end
    check("strobe_seen", 64'(ifc_wen | ifc_ren), 64'(1));
  endtask

  task automatic respond(input bit q, input logic [DW-1:0] d, input int gap);
    wait_strobe(8);
    repeat (gap + 1) tick();
    rdq.push_back('{spi: !q, qspi: q, data: d});
    ifc_rvalid = 1'b1; ifc_rdata = d;
    tick();
    ifc_rvalid = 1'b0;
    if (q) check("rd_q_latency", 64'({qspi_rvalid, spi_rvalid, qspi_rdata}), 64'({1'b1, 1'b0, d}));
    else check("rd_s_latency", 64'({spi_rvalid, qspi_rvalid, spi_rdata}), 64'({1'b1, 1'b0, d}));
  endtask

  initial begin
    repeat (3) tick();
    check("rst_outs", 64'({ifc_wen, ifc_ren, spi_rvalid, qspi_rvalid, rd_timeout, err_sticky, drop_cnt}), 64'(0));
    check("rst_addr_data", 64'({ifc_addr, ifc_wdata}), 64'(0));
    check("rst_rdata", 64'({spi_rdata, qspi_rdata}), 64'(0));
    rst_n = 1'b1;
    repeat (2) tick();

    // single SPI write: strobe two cycles after the pulse
    drive(0, 1, 8'h10, 16'hA5A5, 1);
    tick(); clr();
    check("wr_c1_quiet", 64'(ifc_wen), 64'(0));
    tick();
    check("wr_c2_strobe", 64'({ifc_wen, ifc_addr, ifc_wdata}), 64'({1'b1, 8'h10, 16'hA5A5}));
    tick();
    check("wr_hold", 64'({ifc_wen, ifc_addr, ifc_wdata}), 64'({1'b0, 8'h10, 16'hA5A5}));
    repeat (2) tick();

    // concurrent reads, data routed to owners only
    drive(0, 0, 8'h20, 16'h0, 1);
    drive(1, 0, 8'h30, 16'h0, 1);
    tick(); clr();
    respond(0, 16'h1111, 0);
    respond(1, 16'h2222, 2);
    repeat (2) tick();
    check("rd_no_err", 64'(err_sticky), 64'(0));

    // starvation: QSPI wins after four SPI grants
    drive(0, 1, 8'hA0, 16'h00A0, 1);
    drive(1, 1, 8'hB0, 16'h0B0B, 0);
    tick(); clr();
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) exq.push_back('{wen: 1'b1, ren: 1'b0, addr: 8'hB0, wdata: 16'h0B0B});
      drive(0, 1, 8'(8'hA0 + i), 16'(16'h00A0 + i), 1);
      tick(); clr();
      tick();
    end
    repeat (8) tick();
    check("starve_drained", 64'(exq.size()), 64'(0));
    check("starve_cnt_zero", 64'(dut.starve_q), 64'(0));
    check("starve_no_drop", 64'({err_sticky, drop_cnt}), 64'(0));

    // timeout after 255 wait cycles
    drive(0, 0, 8'h40, 16'h0, 1);
    tick(); clr();
    wait_strobe(4);
    repeat (255) tick();
    rdq.push_back('{spi: 1'b1, qspi: 1'b0, data: 16'hFFFF});
    tick();
    check("tmo_resp", 64'({spi_rvalid, rd_timeout, spi_rdata}), 64'({1'b1, 1'b1, 16'hFFFF}));
    tick();
    check("tmo_once", 64'({rd_timeout, 32'(to_cnt)}), 64'({1'b0, 32'd1}));

    // real data on the final wait cycle beats the timeout
    drive(1, 0, 8'h44, 16'h0, 1);
    tick(); clr();
    wait_strobe(4);
    repeat (255) tick();
    rdq.push_back('{spi: 1'b0, qspi: 1'b1, data: 16'h3333});
    ifc_rvalid = 1'b1; ifc_rdata = 16'h3333;
    tick();
    ifc_rvalid = 1'b0;
    check("tie_data_wins", 64'({qspi_rvalid, rd_timeout, qspi_rdata}), 64'({1'b1, 1'b0, 16'h3333}));
    repeat (2) tick();
    check("tie_tmo_count", 64'(to_cnt), 64'(1));

    // drops while the FSM waits on a read
    drive(0, 0, 8'h50, 16'h0, 1);
    tick(); clr();
    wait_strobe(4);
    tick();
    drive(0, 1, 8'h60, 16'h6666, 1);
    drive(1, 1, 8'h70, 16'h7777, 1);
    tick(); clr();
    drive(0, 1, 8'h61, 16'h6161, 0);
    tick(); clr();
    check("drop_one", 64'({err_sticky[0], drop_cnt}), 64'({1'b1, 8'd1}));
    for (int i = 0; i < 130; i++) begin
      drive(0, 1, 8'h62, 16'h6262, 0);
      drive(1, 1, 8'h72, 16'h7272, 0);
      tick();
      if (i == 99) check("drop_201", 64'(drop_cnt), 64'(201));
    end
    clr();
    check("drop_sat", 64'(drop_cnt), 64'(255));
    rdq.push_back('{spi: 1'b1, qspi: 1'b0, data: 16'h5555});
    ifc_rvalid = 1'b1; ifc_rdata = 16'h5555;
    tick();
    ifc_rvalid = 1'b0;
    check("drop_rd_resp", 64'({spi_rvalid, spi_rdata}), 64'({1'b1, 16'h5555}));
    repeat (8) tick();

    // reset in WAIT_RD, then a stale ifc_rvalid
    drive(0, 0, 8'h80, 16'h0, 1);
    tick(); clr();
    wait_strobe(4);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid", 64'({ifc_wen, ifc_ren, spi_rvalid, qspi_rvalid, rd_timeout, err_sticky, drop_cnt}), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    ifc_rvalid = 1'b1; ifc_rdata = 16'h9999;
    tick();
    ifc_rvalid = 1'b0;
    check("late_no_resp", 64'({spi_rvalid, qspi_rvalid}), 64'(0));
    tick();
    check("late_err", 64'(err_sticky), 64'(2'b10));
    repeat (2) tick();

    check("exq_empty", 64'(exq.size()), 64'(0));
    check("rdq_empty", 64'(rdq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/intf_arbiter.md
Name: intf_arbiter

Overview:
Arbitrates between the spi_slave and qspi_slave register-access ports and issues single transactions to array_top's interface_* port. Each source gets a one-entry request buffer, so a concurrent request from the loser is held rather than lost. Reads are tracked by owner, so read data returns only to the requester; array_top read data is no longer broadcast to both sources. Unanswered reads are bounded by a timeout, and the arbiter includes anti-starvation for the low-priority QSPI source.

Parameters:
DW, `INTERFACE_DATA_WIDTH, data width
AW, `INTERFACE_ADDR_WIDTH, address width
RD_TIMEOUT, 255, cycles to wait for ifc_rvalid before forcing a response
TIMEOUT_DATA, all-ones (DW bits), rdata returned on timeout
STARVE_LIM, 4, consecutive SPI grants allowed while QSPI is pending

Ports:
clk  in  1  chip clock, single domain
rst_n  in  1  asynchronous active-low reset
spi_addr  in  AW  SPI request address
spi_wen  in  1  SPI write pulse
spi_ren  in  1  SPI read pulse
spi_wdata  in  DW  SPI write data
spi_rdata  out  DW  read data to SPI
spi_rvalid  out  1  one-cycle read-return pulse to SPI
qspi_addr, qspi_wen, qspi_ren, qspi_wdata, qspi_rdata, qspi_rvalid  same as spi_*, for QSPI
ifc_addr  out  AW  to array_top interface_addr
ifc_wen  out  1  to interface_wen
ifc_wdata  out  DW  to interface_wdata
ifc_ren  out  1  to interface_ren
ifc_rdata  in  DW  from interface_rdata
ifc_rvalid  in  1  from interface_rvalid
rd_timeout  out  1  one-cycle pulse when a read times out
err_sticky  out  2  bit0: request dropped (buffer full or wen and ren together); bit1: unexpected ifc_rvalid
drop_cnt  out  8  saturating count of dropped requests

Behaviour:
Reset values:
- All outputs 0; all buffers empty.
- FSM in IDLE; starvation counter 0.

Request capture (per source):
- A wen or ren pulse with the buffer empty loads {addr, wdata, is_write}; the buffer is marked full at the next edge.
- A buffer being granted this cycle counts as empty, so a same-cycle pulse is captured.
- A pulse into a full buffer is dropped: set err_sticky[0] and increment drop_cnt.
- wen and ren in the same cycle: the write is captured, the read is dropped and counted.

FSM, states IDLE, ISSUE, WAIT_RD:
- IDLE: grant SPI if its buffer is full, else QSPI if full.
  - Exception: if QSPI is pending and starve_cnt equals STARVE_LIM, QSPI wins.
  - Record the owner, clear that buffer, register ifc_addr/ifc_wdata, go to ISSUE.
- starve_cnt increments on each SPI grant while QSPI is pending and clears on any QSPI grant. It does not clear on an SPI grant made while QSPI is idle.
- ISSUE: ifc_wen or ifc_ren is high for exactly this one cycle.
  - Write: go to IDLE.
  - Read: go to WAIT_RD and clear the timer.
- WAIT_RD:
  - On ifc_rvalid, latch ifc_rdata into the owner's rdata and pulse the owner's rvalid next cycle; go to IDLE.
  - If the timer reaches RD_TIMEOUT first, return TIMEOUT_DATA with the owner's rvalid, pulse rd_timeout, go to IDLE.
  - ifc_rvalid and timeout in the same cycle: the real data wins.
- ifc_rvalid in IDLE or ISSUE is ignored and sets err_sticky[1].
- ifc_addr and ifc_wdata hold their last values between transactions.

Latency and throughput:
- Pulse at cycle t with the arbiter idle: buffer full at t+1, granted at t+1, ifc_wen/ifc_ren high at t+2.
- ifc_rvalid at cycle r: owner's rvalid high at r+1.
- Peak throughput: one write every 2 cycles.
- The non-owner's rvalid is never asserted.

Reset mid-operation: all state is discarded and no rvalid is produced. A late ifc_rvalid after reset sets err_sticky[1].

Decomposition:
- Package intf_arb_pkg:
  - state_t enum {IDLE, ISSUE, WAIT_RD}
  - owner_t enum {OWN_SPI, OWN_QSPI}
  - req_t struct {addr, wdata, is_write}
  - drop-counter width constant
- Sub-module intf_req_buf: one-entry request buffer with capture, grant-clear and drop detection, instantiated twice (SPI, QSPI).

Test Plan:
- SPI write (addr 0x10, data 0xA5A5) at cycle 0 -> ifc_wen=1 at cycle 2 with addr 0x10 and data 0xA5A5; qspi_rvalid and spi_rvalid stay 0.
- SPI and QSPI reads in the same cycle; array_top returns 0x1111 then 0x2222 -> spi_rdata=0x1111, then qspi_rdata=0x2222; each rvalid pulses once, only on the owning port.
- SPI requests continuously with QSPI pending -> QSPI granted after exactly 4 SPI grants; starve_cnt then 0.
- Read with ifc_rvalid withheld -> at 255 wait cycles, the owner sees rvalid with rdata=0xFFFF and rd_timeout pulses once.
- Two SPI pulses while the first is still buffered -> second dropped; drop_cnt=1, err_sticky[0]=1; 256+ drops saturate drop_cnt at 255.
- rst_n asserted in WAIT_RD, then ifc_rvalid after release -> no rvalid on either port; err_sticky[1]=1.
